// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Brief    : Shared types and constants for the instruction-fetch stage.
// Revision : 1.0
// ============================================================================
package fetch_pkg;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam int unsigned PC_STEP   = 4;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_skid_buf.sv
`default_nettype none
// ============================================================================
// Module   : fetch_skid_buf
// Brief    : Single-entry skid buffer holding a fetched word across a stall.
// Revision : 1.0
// ============================================================================
module fetch_skid_buf (
    input  logic        clk,
    input  logic        reset,
    input  logic        capture,
    input  logic        clear,
    input  logic [31:0] data_in,
    output logic        valid,
    output logic [31:0] data
);

    logic        r_valid;
    logic [31:0] r_data;

    // Clear wins: a redirect or advance consumes/discards the held word.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= 32'h0;
        end else if (clear) begin
            r_valid <= 1'b0;
        end else if (capture) begin
            r_valid <= 1'b1;
            r_data  <= data_in;
        end
    end

    assign valid = r_valid;
    assign data  = r_data;

endmodule : fetch_skid_buf
`default_nettype wire

// File: rtl/fetch_pc_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pc_stage
// Brief    : PC register, sync-imem fetch tracking, skid buffer and IF/ID
//            register with redirect squash. FETCH_PERF_CNT_EN adds counters.
// Revision : 1.0
// ============================================================================
module fetch_pc_stage #(
    parameter int          PC_W      = 9,
    parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            PcSel,
    input  logic [31:0]     BrPC,
    input  logic            Stall,
    input  logic [31:0]     Instr_in,
    output logic [PC_W-1:0] PC_Addr,
    output logic [PC_W-1:0] IfId_PC,
    output logic [31:0]     IfId_Instr,
    output logic            IfId_Valid,
    output logic            Flush_Out,
    output logic            Misalign_Err,
    output logic [31:0]     Fetch_Count,
    output logic [31:0]     Squash_Count
);

    import fetch_pkg::*;

    fetch_state_e    r_state;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] r_fetch_pc;
    logic            r_fetch_valid;
    logic [PC_W-1:0] r_ifid_pc;
    logic [31:0]     r_ifid_instr;
    logic            r_ifid_valid;
    logic            r_misalign;

    logic            w_run;
    logic            w_aligned;
    logic            w_redirect;
    logic            w_advance;
    logic            w_load_valid;
    logic            w_skid_capture;
    logic            w_skid_clear;
    logic            w_skid_valid;
    logic [31:0]     w_skid_data;
    logic [31:0]     w_next_instr;
    logic            w_unused_brpc_hi;

    assign w_run          = (r_state == ST_RUN);
    assign w_aligned      = (BrPC[1:0] == 2'b00);
    assign w_redirect     = w_run && PcSel && w_aligned;
    assign w_advance      = w_run && !PcSel && !Stall;
    assign w_load_valid   = w_advance && r_fetch_valid;
    // Only the first stalled cycle's word belongs to the in-flight fetch.
    assign w_skid_capture = w_run && !PcSel && Stall && r_fetch_valid && !w_skid_valid;
    assign w_skid_clear   = w_redirect || w_advance;
    assign w_next_instr   = w_skid_valid ? w_skid_data : Instr_in;
    assign w_unused_brpc_hi = ^BrPC[31:PC_W];

    fetch_skid_buf u_skid (
        .clk     (clk),
        .reset   (reset),
        .capture (w_skid_capture),
        .clear   (w_skid_clear),
        .data_in (Instr_in),
        .valid   (w_skid_valid),
        .data    (w_skid_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_RUN;
            r_pc          <= '0;
            r_fetch_pc    <= '0;
            r_fetch_valid <= 1'b0;
            r_ifid_pc     <= '0;
            r_ifid_instr  <= NOP_INSTR;
            r_ifid_valid  <= 1'b0;
            r_misalign    <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (PcSel) begin
                        r_ifid_valid <= 1'b0;
                        r_ifid_instr <= NOP_INSTR;
                        if (w_aligned) begin
                            r_pc          <= BrPC[PC_W-1:0];
                            r_fetch_valid <= 1'b0;
                        end else begin
                            r_state    <= ST_HALT;
                            r_misalign <= 1'b1;
                        end
                    end else if (!Stall) begin
                        r_pc          <= r_pc + PC_W'(PC_STEP);
                        r_fetch_pc    <= r_pc;
                        r_fetch_valid <= 1'b1;
                        r_ifid_pc     <= r_fetch_pc;
                        r_ifid_valid  <= r_fetch_valid;
                        r_ifid_instr  <= r_fetch_valid ? w_next_instr : NOP_INSTR;
                    end
                end
                ST_HALT: begin
                end
                default: begin
                    r_state <= ST_HALT;
                end
            endcase
        end
    end

    assign PC_Addr      = r_pc;
    assign IfId_PC      = r_ifid_pc;
    assign IfId_Instr   = r_ifid_instr;
    assign IfId_Valid   = r_ifid_valid;
    assign Misalign_Err = r_misalign;
    assign Flush_Out    = PcSel && w_run;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_fetch_count;
    logic [31:0] r_squash_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_count  <= 32'h0;
            r_squash_count <= 32'h0;
        end else begin
            if (w_load_valid) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end
            if (w_redirect) begin
                r_squash_count <= r_squash_count + 32'd1;
            end
        end
    end

    assign Fetch_Count  = r_fetch_count;
    assign Squash_Count = r_squash_count;
`else
    assign Fetch_Count  = 32'h0;
    assign Squash_Count = 32'h0;
`endif

endmodule : fetch_pc_stage
`default_nettype wire

// File: tb/tb_fetch_pc_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_pc_stage
// Brief    : Self-checking bench: directed vector table, corner sequences and
//            random traffic against a queue-based fetch-stream model.
// Revision : 1.0
// ============================================================================
module tb_fetch_pc_stage;

    localparam int          PC_W   = 9;
    localparam int          PC_MSK = (1 << PC_W) - 1;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            PcSel = 1'b0;
    logic [31:0]     BrPC = 32'h0;
    logic            Stall = 1'b0;
    logic [31:0]     Instr_in = 32'h0;
    logic [PC_W-1:0] PC_Addr;
    logic [PC_W-1:0] IfId_PC;
    logic [31:0]     IfId_Instr;
    logic            IfId_Valid;
    logic            Flush_Out;
    logic            Misalign_Err;
    logic [31:0]     Fetch_Count;
    logic [31:0]     Squash_Count;

    int checks = 0;
    int errors = 0;

    fetch_pc_stage #(.PC_W(PC_W), .NOP_INSTR(NOP)) dut (
        .clk          (clk),
        .reset        (reset),
        .PcSel        (PcSel),
        .BrPC         (BrPC),
        .Stall        (Stall),
        .Instr_in     (Instr_in),
        .PC_Addr      (PC_Addr),
        .IfId_PC      (IfId_PC),
        .IfId_Instr   (IfId_Instr),
        .IfId_Valid   (IfId_Valid),
        .Flush_Out    (Flush_Out),
        .Misalign_Err (Misalign_Err),
        .Fetch_Count  (Fetch_Count),
        .Squash_Count (Squash_Count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input int a);
        return 32'hC0DE_0000 | 32'(a & PC_MSK);
    endfunction

    // Synchronous instruction memory, one-cycle read latency.
    always @(posedge clk) Instr_in <= mem_word(int'(PC_Addr));

    // Stream model: PC, the one outstanding fetch address, and IF/ID contents.
    int          m_pc, m_if_pc;
    int          pending[$];
    bit          m_if_v, m_halt, m_err;
    logic [31:0] m_fc, m_sc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_edge(input bit rst, input bit ps, input bit st, input logic [31:0] br);
        if (rst) begin
            m_pc = 0; pending.delete(); m_if_v = 0; m_if_pc = 0;
            m_halt = 0; m_err = 0; m_fc = 0; m_sc = 0;
        end else if (m_halt) begin
        end else if (ps) begin
            m_if_v = 0;
            if (br[1:0] != 2'b00) begin
                m_halt = 1; m_err = 1;
            end else begin
                m_pc = int'(br) & PC_MSK;
                pending.delete();
                m_sc++;
            end
        end else if (!st) begin
            if (pending.size() > 0) begin
                m_if_v = 1; m_if_pc = pending.pop_front(); m_fc++;
            end else begin
                m_if_v = 0;
            end
            pending.push_back(m_pc);
            m_pc = (m_pc + 4) & PC_MSK;
        end
    endtask

    task automatic check_model();
        chk("pc_addr", 32'(PC_Addr), 32'(m_pc));
        chk("ifid_valid", 32'(IfId_Valid), 32'(m_if_v));
        if (m_if_v) begin
            chk("ifid_pc", 32'(IfId_PC), 32'(m_if_pc));
            chk("ifid_instr", IfId_Instr, mem_word(m_if_pc));
        end else begin
            chk("ifid_nop", IfId_Instr, NOP);
        end
        chk("misalign_err", 32'(Misalign_Err), 32'(m_err));
`ifdef FETCH_PERF_CNT_EN
        chk("fetch_count", Fetch_Count, m_fc);
        chk("squash_count", Squash_Count, m_sc);
`else
        chk("fetch_count_off", Fetch_Count, 32'h0);
        chk("squash_count_off", Squash_Count, 32'h0);
`endif
    endtask

    task automatic step(input bit rst, input bit ps, input bit st, input logic [31:0] br,
                        output bit flush_seen);
        @(negedge clk);
        reset = rst; PcSel = ps; Stall = st; BrPC = br;
        #1;
        flush_seen = Flush_Out;
        if (!rst) chk("flush_out", 32'(Flush_Out), 32'(ps && !m_halt));
        @(posedge clk);
        model_edge(rst, ps, st, br);
        #1;
        check_model();
    endtask

    typedef struct {
        bit          ps;
        bit          st;
        logic [31:0] br;
        int          exp_pc;
        bit          exp_v;
        int          exp_ifpc;
        bit          exp_err;
        bit          exp_flush;
    } vec_t;

    vec_t vecs[16];
    bit   fl;
    int   halt_cycles;

    initial begin
        vecs[0]  = '{0, 0, 32'h0,   'h004, 0, 0,     0, 0};
        vecs[1]  = '{0, 0, 32'h0,   'h008, 1, 'h000, 0, 0};
        vecs[2]  = '{0, 0, 32'h0,   'h00C, 1, 'h004, 0, 0};
        vecs[3]  = '{0, 1, 32'h0,   'h00C, 1, 'h004, 0, 0};
        vecs[4]  = '{0, 1, 32'h0,   'h00C, 1, 'h004, 0, 0};
        vecs[5]  = '{0, 1, 32'h0,   'h00C, 1, 'h004, 0, 0};
        vecs[6]  = '{0, 0, 32'h0,   'h010, 1, 'h008, 0, 0};
        vecs[7]  = '{1, 0, 32'h40,  'h040, 0, 0,     0, 1};
        vecs[8]  = '{0, 0, 32'h0,   'h044, 0, 0,     0, 0};
        vecs[9]  = '{0, 0, 32'h0,   'h048, 1, 'h040, 0, 0};
        vecs[10] = '{1, 1, 32'h80,  'h080, 0, 0,     0, 1};
        vecs[11] = '{0, 0, 32'h0,   'h084, 0, 0,     0, 0};
        vecs[12] = '{0, 0, 32'h0,   'h088, 1, 'h080, 0, 0};
        vecs[13] = '{0, 1, 32'h0,   'h088, 1, 'h080, 0, 0};
        vecs[14] = '{1, 0, 32'h42,  'h088, 0, 0,     1, 1};
        vecs[15] = '{1, 0, 32'h40,  'h088, 0, 0,     1, 0};

        model_edge(1, 0, 0, 0);
        step(1, 0, 0, 32'h0, fl);
        step(1, 0, 0, 32'h0, fl);
        chk("reset_ifid_instr", IfId_Instr, NOP);
        chk("reset_pc", 32'(PC_Addr), 32'h0);

        for (int i = 0; i < 16; i++) begin
            step(0, vecs[i].ps, vecs[i].st, vecs[i].br, fl);
            chk($sformatf("vec%0d_flush", i), 32'(fl), 32'(vecs[i].exp_flush));
            chk($sformatf("vec%0d_pc", i), 32'(PC_Addr), 32'(vecs[i].exp_pc));
            chk($sformatf("vec%0d_valid", i), 32'(IfId_Valid), 32'(vecs[i].exp_v));
            if (vecs[i].exp_v)
                chk($sformatf("vec%0d_ifpc", i), 32'(IfId_PC), 32'(vecs[i].exp_ifpc));
            chk($sformatf("vec%0d_err", i), 32'(Misalign_Err), 32'(vecs[i].exp_err));
        end

        // PC wrap at the top of the address space, then a truncated redirect.
        step(1, 0, 0, 32'h0, fl);
        step(0, 1, 0, 32'h1F8, fl);
        step(0, 0, 0, 32'h0, fl);
        step(0, 0, 0, 32'h0, fl);
        chk("wrap_pc", 32'(PC_Addr), 32'h000);
        step(0, 0, 0, 32'h0, fl);
        chk("wrap_ifpc", 32'(IfId_PC), 32'h1FC);
        step(0, 0, 0, 32'h0, fl);
        chk("wrap_ifpc0", 32'(IfId_PC), 32'h000);
        step(0, 1, 0, 32'hFFFF_FE04, fl);
        chk("trunc_pc", 32'(PC_Addr), 32'h004);
        chk("trunc_err", 32'(Misalign_Err), 32'h0);

        // Misaligned redirect: frozen for a dozen cycles despite more redirects.
        step(0, 1, 0, 32'h42, fl);
        for (int i = 0; i < 12; i++) begin
            step(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 32'h100, fl);
            chk("halt_pc", 32'(PC_Addr), 32'h004);
            chk("halt_valid", 32'(IfId_Valid), 32'h0);
            chk("halt_err", 32'(Misalign_Err), 32'h1);
        end
        step(1, 0, 0, 32'h0, fl);
        chk("post_halt_err", 32'(Misalign_Err), 32'h0);

        halt_cycles = 0;
        for (int i = 0; i < 1500; i++) begin
            bit          r, p, s;
            logic [31:0] b;
            r = (halt_cycles > 15) || ($urandom_range(0, 199) == 0);
            p = ($urandom_range(0, 11) == 0);
            s = ($urandom_range(0, 3) == 0);
            b = $urandom;
            if ($urandom_range(0, 7) != 0) b[1:0] = 2'b00;
            step(r, p, s, b, fl);
            halt_cycles = m_halt ? halt_cycles + 1 : 0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule : tb_fetch_pc_stage
`default_nettype wire
